// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a 16-byte register window feeds a byte FIFO
// that a baud-timed FSM drains onto uart_tx, LSB first.
module mmio_uart_tx #(
  parameter logic [31:0] MMIO_BASE   = 32'h0000_F000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic        mmio_hit,
  output logic        uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          hit;
  logic [1:0]    offset;
  logic          wr_txdata, wr_status, wr_baud;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          full, empty, push_ok, pop;
  logic          overflow;
  logic [15:0]   baud_div, div_q, baud_cnt;
  logic [1:0]    state;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          busy;
  logic [31:0]   status;
  logic          unused_ok;

  assign hit       = (mem_addr[31:4] == MMIO_BASE[31:4]);
  assign offset    = mem_addr[3:2];
  assign unused_ok = ^{mem_addr[1:0], mem_wr_data[31:16]};

  assign wr_txdata = mem_wr_ena && hit && (offset == 2'd0);
  assign wr_status = mem_wr_ena && hit && (offset == 2'd1);
  assign wr_baud   = mem_wr_ena && hit && (offset == 2'd2);

  assign full    = (count == 5'(FIFO_DEPTH));
  assign empty   = (count == 5'd0);
  assign pop     = (state == S_IDLE) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = wr_txdata && (!full || pop);
  assign busy    = (state != S_IDLE);
  assign status  = {23'd0, count, overflow, busy, empty, full};

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= mem_wr_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
      baud_div <= DEFAULT_DIV;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (wr_txdata && full && !pop)         overflow <= 1'b1;
      else if (wr_status && mem_wr_data[3]) overflow <= 1'b0;
      if (wr_baud) baud_div <= (mem_wr_data[15:0] == 16'd0) ? 16'd1 : mem_wr_data[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_rd_data <= 32'd0;
      mmio_hit    <= 1'b0;
    end else begin
      mmio_hit <= hit;
      if (!hit) mem_rd_data <= 32'd0;
      else begin
        case (offset)
          2'd1:    mem_rd_data <= status;
          2'd2:    mem_rd_data <= {16'd0, baud_div};
          default: mem_rd_data <= 32'd0;
        endcase
      end
    end
  end

  // uart_tx is loaded with the level of the state being entered so it stays registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      uart_tx  <= 1'b1;
      shreg    <= 8'd0;
      div_q    <= 16'd1;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (!empty) begin
            shreg    <= fifo_mem[rd_ptr];
            div_q    <= baud_div;
            baud_cnt <= baud_div - 16'd1;
            uart_tx  <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_cnt == 16'd0) begin
            state    <= S_DATA;
            bit_idx  <= 3'd0;
            baud_cnt <= div_q - 16'd1;
            uart_tx  <= shreg[0];
          end else baud_cnt <= baud_cnt - 16'd1;
        end
        S_DATA: begin
          if (baud_cnt == 16'd0) begin
            baud_cnt <= div_q - 16'd1;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state   <= S_STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shreg[1];
            end
          end else baud_cnt <= baud_cnt - 16'd1;
        end
        S_STOP: begin
          if (baud_cnt == 16'd0) state <= S_IDLE;
          else                   baud_cnt <= baud_cnt - 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx: register access, frame shape and
// timing, FIFO overflow, decode, mid-frame divisor change and reset.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;
  logic        mmio_hit;
  logic        uart_tx;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] A_TX   = 32'h0000_F000;
  localparam logic [31:0] A_STAT = 32'h0000_F004;
  localparam logic [31:0] A_BAUD = 32'h0000_F008;
  localparam logic [31:0] A_RSV  = 32'h0000_F00C;

  mmio_uart_tx dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ena(mem_wr_ena), .mem_rd_data(mem_rd_data), .mmio_hit(mmio_hit),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_addr = a; mem_wr_data = d; mem_wr_ena = 1'b1;
    tick();
    mem_wr_ena = 1'b0; mem_addr = 32'd0; mem_wr_data = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    mem_addr = a; mem_wr_ena = 1'b0;
    tick();
    d = mem_rd_data; h = mmio_hit;
    mem_addr = 32'd0;
  endtask

  // Samples the line once per clock from the current start-bit cycle (skip cycles
  // of the start bit already elapsed) through the stop bit; every bit must hold for d clocks.
  task automatic rx_frame(input int d, input int skip, output logic [7:0] data, output logic ok);
    logic v;
    ok = 1'b1; data = 8'd0;
    for (int b = 0; b < 10; b++) begin
      for (int c = (b == 0) ? skip : 0; c < d; c++) begin
        v = uart_tx;
        if (b == 0) begin
          if (v !== 1'b0) ok = 1'b0;
        end else if (b == 9) begin
          if (v !== 1'b1) ok = 1'b0;
        end else if (c == 0) data[b-1] = v;
        else if (v !== data[b-1]) ok = 1'b0;
        tick();
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        h;
    logic [7:0]  rb;
    logic        ok;
    logic        quiet;
    logic [7:0]  exp3 [3];
    exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'h3C;

    // Reset with random bus activity
    rst = 1'b0; mem_addr = 32'd0; mem_wr_data = 32'd0; mem_wr_ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_addr    = {20'h0000F, 12'($urandom_range(0, 15))};
      mem_wr_data = $urandom;
      mem_wr_ena  = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_rd", mem_rd_data, 32'd0);
    chk("rst_hit", {31'd0, mmio_hit}, 32'd0);
    mem_addr = 32'd0; mem_wr_ena = 1'b0; mem_wr_data = 32'd0;
    rst = 1'b1;
    rd(A_STAT, d, h); chk("rst_status", d, 32'h002);
    rd(A_BAUD, d, h); chk("rst_baud", d, 32'd868);

    // Single byte 0xA5 at DIV=4
    wr(A_BAUD, 32'd4);
    wr(A_TX, 32'h0000_00A5);
    chk("push_edge_tx_high", {31'd0, uart_tx}, 32'd1);
    rd(A_STAT, d, h); chk("status_after_push", d, 32'h010);
    rx_frame(4, 0, rb, ok);
    chk("a5_timing", {31'd0, ok}, 32'd1);
    chk("a5_data", {24'd0, rb}, 32'hA5);
    chk("a5_idle_after", {31'd0, uart_tx}, 32'd1);
    rd(A_STAT, d, h); chk("a5_not_busy", d, 32'h002);

    // Back-to-back frames at DIV=2
    wr(A_BAUD, 32'd2);
    wr(A_TX, 32'h00); wr(A_TX, 32'hFF); wr(A_TX, 32'h3C);
    for (int f = 0; f < 3; f++) begin
      rx_frame(2, (f == 0) ? 1 : 0, rb, ok);
      chk("b2b_timing", {31'd0, ok}, 32'd1);
      chk("b2b_data", {24'd0, rb}, {24'd0, exp3[f]});
      chk("b2b_gap", {31'd0, uart_tx}, 32'd1);
      tick();
    end
    rd(A_STAT, d, h); chk("b2b_drained", d, 32'h002);

    // Overflow: 10 pushes, depth 8, DIV=20 keeps the first frame in its start bit
    wr(A_BAUD, 32'd20);
    for (int i = 0; i < 10; i++) wr(A_TX, 32'(8'h11 * (i + 1)));
    rd(A_STAT, d, h); chk("ovf_status", d, 32'h08D);
    wr(A_STAT, 32'h8);
    rd(A_STAT, d, h); chk("ovf_cleared", d, 32'h085);
    for (int f = 0; f < 9; f++) begin
      rx_frame(20, (f == 0) ? 11 : 0, rb, ok);
      chk("ovf_timing", {31'd0, ok}, 32'd1);
      chk("ovf_data", {24'd0, rb}, 32'(8'h11 * (f + 1)));
      if (f < 8) tick();
    end
    quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (uart_tx !== 1'b1) quiet = 1'b0;
      tick();
    end
    chk("ovf_no_tenth", {31'd0, quiet}, 32'd1);

    // Decode and read latency
    rd(A_STAT, d, h);
    chk("dec_stat_hit", {31'd0, h}, 32'd1);
    chk("dec_stat_val", d, 32'h002);
    rd(32'h0000_F006, d, h); chk("dec_lowbits", d, 32'h002);
    rd(A_TX, d, h);
    chk("dec_tx_hit", {31'd0, h}, 32'd1);
    chk("dec_tx_zero", d, 32'd0);
    rd(32'h0000_F010, d, h);
    chk("dec_f010_hit", {31'd0, h}, 32'd0);
    chk("dec_f010_dat", d, 32'd0);
    rd(32'h0000_0000, d, h);
    chk("dec_0_hit", {31'd0, h}, 32'd0);
    chk("dec_0_dat", d, 32'd0);
    wr(A_RSV, 32'hFFFF_FFFF);
    rd(A_RSV, d, h); chk("rsv_read", d, 32'd0);
    rd(A_STAT, d, h); chk("rsv_status", d, 32'h002);
    rd(A_BAUD, d, h); chk("rsv_baud", d, 32'd20);
    chk("rsv_tx", {31'd0, uart_tx}, 32'd1);
    wr(A_BAUD, 32'hABCD_0005);
    rd(A_BAUD, d, h); chk("baud_upper", d, 32'd5);
    wr(A_BAUD, 32'd0);
    rd(A_BAUD, d, h); chk("baud_zero", d, 32'd1);

    // Divisor change mid-frame applies to the next frame only
    wr(A_BAUD, 32'd3);
    wr(A_TX, 32'h5A);
    wr(A_BAUD, 32'd7);
    rx_frame(3, 0, rb, ok);
    chk("oldiv_timing", {31'd0, ok}, 32'd1);
    chk("oldiv_data", {24'd0, rb}, 32'h5A);
    wr(A_TX, 32'hC3);
    chk("newdiv_pre", {31'd0, uart_tx}, 32'd1);
    tick();
    rx_frame(7, 0, rb, ok);
    chk("newdiv_timing", {31'd0, ok}, 32'd1);
    chk("newdiv_data", {24'd0, rb}, 32'hC3);

    // Reset mid-frame with a second byte queued
    wr(A_TX, 32'hF0);
    wr(A_TX, 32'h0F);
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b0;
    tick();
    chk("mrst_tx", {31'd0, uart_tx}, 32'd1);
    chk("mrst_hit", {31'd0, mmio_hit}, 32'd0);
    rst = 1'b1;
    rd(A_STAT, d, h); chk("mrst_status", d, 32'h002);
    rd(A_BAUD, d, h); chk("mrst_baud", d, 32'd868);
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (uart_tx !== 1'b1) quiet = 1'b0;
      tick();
    end
    chk("mrst_quiet", {31'd0, quiet}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
